// File: rtl/aes_iter_encrypt_pkg.sv
// Shared definitions for the iterative AES encrypt engine: key-length codes,
// FSM states, GF(2^8) helpers, S-box, key schedule and round-key extraction.
package aes_iter_encrypt_pkg;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  // Expanded schedule: word i of the FIPS-197 w[] array lives at index i
  typedef logic [59:0][31:0] sched_t;

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, zero maps to zero) plus affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    inv  = gf_mul(gf_mul(a240, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Key is right-justified, so the first Nk words sit directly below bit 32*Nk
  function automatic sched_t expand(input logic [255:0] key, input int nk);
    sched_t     w;
    logic [31:0] t;
    logic [7:0]  rcon;
    w    = '0;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[32*(nk-i)-1 -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
          rcon = xtime(rcon);
        end else if (nk == 8 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return w;
  endfunction

  function automatic sched_t key_schedule(input logic [255:0] key, input logic [1:0] kl);
    case (kl)
      KL_128:  return expand(key, 32'sd4);
      KL_192:  return expand(key, 32'sd6);
      default: return expand(key, 32'sd8);
    endcase
  endfunction

  // Round key 0 is just the leading four key words; no expansion needed
  function automatic logic [127:0] first_key(input logic [255:0] key, input logic [1:0] kl);
    case (kl)
      KL_128:  return key[127:0];
      KL_192:  return key[191:64];
      default: return key[255:128];
    endcase
  endfunction

  function automatic logic [127:0] round_key(input sched_t s, input logic [3:0] idx);
    logic [5:0] b;
    b = (idx > 4'd14) ? 6'd56 : {idx, 2'b00};
    return {s[b], s[b + 6'd1], s[b + 6'd2], s[b + 6'd3]};
  endfunction

endpackage

// File: rtl/aes_iter_encrypt_if.sv
// Streaming handshake bundle for the AES engine: block/key input and result output.
interface aes_iter_encrypt_if #(
  parameter int KEY_W = 256
);
  logic [1:0]       key_len;
  logic [KEY_W-1:0] key_in;
  logic [127:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output key_len, key_in, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  key_len, key_in, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/aes_iter_encrypt_round.sv
// One combinational AES cipher round; the final round bypasses MixColumns.
module aes_round
  import aes_iter_encrypt_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);
  logic [15:0][7:0] sr_s;
  logic [31:0]      col_s;

  // SubBytes fused with ShiftRows: byte (r,c) takes input byte (r, c+r mod 4)
  always_comb begin
    sr_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[4*c+r] = sbox(state_in[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

  // MixColumns per column (unless last) followed by AddRoundKey
  always_comb begin
    state_out = '0;
    col_s     = '0;
    for (int c = 0; c < 4; c++) begin
      col_s = {sr_s[4*c], sr_s[4*c+1], sr_s[4*c+2], sr_s[4*c+3]};
      state_out[127-32*c -: 32] = (last ? col_s : mix_col(col_s)) ^ round_key[127-32*c -: 32];
    end
  end
endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128/192/256 encryptor: one block per transaction, ROUNDS_PER_CYCLE rounds per clock.
module aes_iter_encrypt
  import aes_iter_encrypt_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int KEY_W            = 256
) (
  input  logic              clk,
  input  logic              rst,
  aes_iter_encrypt_if.slave bus
);
  state_t                              fsm_r, fsm_s;
  logic [127:0]                        st_r, out_data_r;
  logic [KEY_W-1:0]                    key_r;
  logic [1:0]                          kl_r;
  logic [3:0]                          rc_r;
  logic                                in_ready_r, out_valid_r, busy_r;
  sched_t                              sched_s;
  logic [3:0]                          nr_s;
  logic                                last_s;
  logic [ROUNDS_PER_CYCLE:0][127:0]    chain_s;

  assign sched_s    = key_schedule(key_r, kl_r);
  assign nr_s       = nr_of(kl_r);
  assign last_s     = (rc_r + 4'(ROUNDS_PER_CYCLE)) == nr_s;
  assign chain_s[0] = st_r;

  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    logic [3:0] idx_s;
    assign idx_s = rc_r + 4'(k + 1);
    aes_round u_round (
      .state_in  (chain_s[k]),
      .round_key (round_key(sched_s, idx_s)),
      .last      (idx_s == nr_s),
      .state_out (chain_s[k+1])
    );
  end

  // Next-state logic; accept only in IDLE, release only on the output handshake
  always_comb begin
    fsm_s = fsm_r;
    case (fsm_r)
      IDLE:    if (bus.in_valid)  fsm_s = RUN;  else fsm_s = IDLE;
      RUN:     if (last_s)        fsm_s = DONE; else fsm_s = RUN;
      DONE:    if (bus.out_ready) fsm_s = IDLE; else fsm_s = DONE;
      default: fsm_s = IDLE;
    endcase
  end

  // State register with handshake flags decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      fsm_r       <= fsm_s;
      in_ready_r  <= (fsm_s == IDLE);
      out_valid_r <= (fsm_s == DONE);
      busy_r      <= (fsm_s != IDLE);
    end
  end

  // Datapath: latch key and whitened block on accept, then iterate rounds
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r       <= '0;
      key_r      <= '0;
      kl_r       <= 2'b00;
      rc_r       <= 4'd0;
      out_data_r <= '0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (bus.in_valid) begin
            key_r <= bus.key_in;
            kl_r  <= bus.key_len;
            st_r  <= bus.in_data ^ first_key(bus.key_in, bus.key_len);
            rc_r  <= 4'd0;
          end
        end
        RUN: begin
          st_r <= chain_s[ROUNDS_PER_CYCLE];
          rc_r <= rc_r + 4'(ROUNDS_PER_CYCLE);
          if (last_s) begin
            out_data_r <= chain_s[ROUNDS_PER_CYCLE];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_data  = out_data_r;
endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Directed bench: FIPS-197 vectors on a 1-round/clk and a 2-round/clk engine, plus stall and reset sequences.
module tb_aes_iter_encrypt;
  import aes_iter_encrypt_pkg::*;

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat1;
    int           lat2;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t tbl[4];

  aes_iter_encrypt_if #(.KEY_W(256)) ifa ();
  aes_iter_encrypt_if #(.KEY_W(256)) ifb ();

  aes_iter_encrypt #(.ROUNDS_PER_CYCLE(1), .KEY_W(256)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  aes_iter_encrypt #(.ROUNDS_PER_CYCLE(2), .KEY_W(256)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_a(input int v);
    ifa.key_len = tbl[v].kl;
    ifa.key_in  = tbl[v].key;
    ifa.in_data = tbl[v].pt;
  endtask

  task automatic load_b(input int v);
    ifb.key_len = tbl[v].kl;
    ifb.key_in  = tbl[v].key;
    ifb.in_data = tbl[v].pt;
  endtask

  task automatic scramble_inputs();
    ifa.key_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ifa.in_data = {$urandom, $urandom, $urandom, $urandom};
    ifa.key_len = ~ifa.key_len;
    ifb.key_in  = ifa.key_in;
    ifb.in_data = ifa.in_data;
    ifb.key_len = ifa.key_len;
  endtask

  // Waits (bounded) at negedges for engine A's out_valid; lat = -1 on timeout
  task automatic wait_a(input int acc, output int lat);
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (ifa.out_valid) lat = cyc - acc;
      else @(negedge clk);
    end
  endtask

  // Runs one table vector through both engines at once; called at a negedge
  task automatic run_vec(input int v);
    int acc, la, lb;
    logic [127:0] da, db;
    chk("a_in_ready_idle", ifa.in_ready, 1'b1);
    chk("b_in_ready_idle", ifb.in_ready, 1'b1);
    load_a(v);
    load_b(v);
    ifa.in_valid = 1'b1;
    ifb.in_valid = 1'b1;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    acc = cyc;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    scramble_inputs();
    chk("a_busy_run", {ifa.busy, ifa.in_ready}, 2'b10);
    chk("b_busy_run", {ifb.busy, ifb.in_ready}, 2'b10);
    la = -1; lb = -1; da = '0; db = '0;
    for (int k = 0; k < 40 && (la < 0 || lb < 0); k++) begin
      @(negedge clk);
      if (la < 0 && ifa.out_valid) begin la = cyc - acc; da = ifa.out_data; end
      if (lb < 0 && ifb.out_valid) begin lb = cyc - acc; db = ifb.out_data; end
    end
    @(negedge clk);
    chk($sformatf("a_ct_v%0d", v), da, tbl[v].ct);
    chk($sformatf("b_ct_v%0d", v), db, tbl[v].ct);
    chk($sformatf("a_lat_v%0d", v), 128'(la), 128'(tbl[v].lat1));
    chk($sformatf("b_lat_v%0d", v), 128'(lb), 128'(tbl[v].lat2));
  endtask

  initial begin
    int acc, lat, seen;

    tbl[0] = '{KL_128, {128'hdeadbeefcafef00d0123456789abcdef, 128'h000102030405060708090a0b0c0d0e0f},
               128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11, 6};
    tbl[1] = '{KL_192, {64'hffffffffffffffff, 192'h000102030405060708090a0b0c0d0e0f1011121314151617},
               128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 13, 7};
    tbl[2] = '{KL_256, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 15, 8};
    tbl[3] = '{2'b11, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 15, 8};

    rst = 1'b1;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
    load_a(0);
    load_b(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {ifa.in_ready, ifb.in_ready}, 2'b11);
    chk("rst_out_valid", {ifa.out_valid, ifb.out_valid}, 2'b00);
    chk("rst_busy", {ifa.busy, ifb.busy}, 2'b00);
    chk("rst_out_data", ifa.out_data, 128'h0);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Back-to-back on engine A: AES-128 stalled 5 cycles, AES-256 waiting behind it
    load_a(0);
    ifa.in_valid = 1'b1;
    ifa.out_ready = 1'b0;
    acc = cyc;
    @(negedge clk);
    load_a(2);
    wait_a(acc, lat);
    chk("stall_lat1", 128'(lat), 128'(11));
    for (int s = 0; s < 5; s++) begin
      chk("stall_data", ifa.out_data, tbl[0].ct);
      chk("stall_flags", {ifa.out_valid, ifa.in_ready}, 2'b10);
      @(negedge clk);
    end
    chk("stall_data_end", ifa.out_data, tbl[0].ct);
    ifa.out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_flags", {ifa.out_valid, ifa.in_ready}, 2'b01);
    acc = cyc;
    @(negedge clk);
    chk("second_accepted", ifa.busy, 1'b1);
    ifa.in_valid = 1'b0;
    wait_a(acc, lat);
    chk("second_ct", ifa.out_data, tbl[2].ct);
    chk("second_lat", 128'(lat), 128'(15));
    @(negedge clk);

    // Reset during round 5 of an AES-256 block, with in_valid high under reset
    load_a(2);
    ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    ifa.in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifa.in_valid = 1'b0;
    chk("midrst_flags", {ifa.in_ready, ifa.out_valid, ifa.busy}, 3'b100);
    chk("midrst_data", ifa.out_data, 128'h0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen += (ifa.out_valid || ifa.busy) ? 1 : 0;
    end
    chk("midrst_no_valid", 128'(seen), 128'(0));
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
